// File: rtl/dma_pkg.sv
// Shared types and constants for the sprite-attribute DMA engine.
package dma_pkg;

    // Engine sequencing states
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HALT  = 3'd1,
        ALIGN = 3'd2,
        READ  = 3'd3,
        WRITE = 3'd4
    } T_dma_state;

    localparam int unsigned C_dma_bytes = 256;
    localparam int unsigned C_count_w   = 8;
    localparam logic [2:0]  C_oam_reg   = 3'd4;

    // True when the byte index addresses the last byte of the page
    function automatic logic is_last_byte(input logic [C_count_w-1:0] count);
        return count == C_count_w'(C_dma_bytes - 1);
    endfunction

endpackage

// File: rtl/oam_dma.sv
// Sprite-attribute DMA: on a CPU write to the trigger address, halts the CPU
// and copies one 256-byte page of CPU memory into the video sprite-data register.
module oam_dma
    import dma_pkg::*;
#(
    parameter logic [15:0] P_trigger_addr = 16'h4014,
    parameter logic [2:0]  P_ppu_reg      = C_oam_reg
) (
    input  logic        I_clock,
    input  logic        I_reset,
    input  logic        I_tick,
    input  logic [15:0] I_cpu_addr,
    input  logic        I_cpu_wren,
    input  logic [7:0]  I_cpu_data,
    output logic        O_cpu_halt,
    output logic [15:0] O_mem_addr,
    output logic        O_mem_rden,
    input  logic [7:0]  I_mem_data,
    output logic [2:0]  O_ppu_addr,
    output logic        O_ppu_wren,
    output logic [7:0]  O_ppu_data,
    output logic        O_busy
);

    T_dma_state           R_state;
    T_dma_state           next_state;
    logic                 R_odd;
    logic [7:0]           R_page;
    logic [C_count_w-1:0] R_count;
    logic [7:0]           R_data;
    logic                 trigger;

    // CPU write to the trigger register (qualified by tick in the sequencer)
    assign trigger = I_cpu_wren && (I_cpu_addr == P_trigger_addr);

    // Next-state decode; HALT skips ALIGN when the following tick is already even
    always_comb begin
        next_state = R_state;
        case (R_state)
            IDLE:    if (trigger) next_state = HALT;
            HALT:    next_state = R_odd ? READ : ALIGN;
            ALIGN:   next_state = READ;
            READ:    next_state = WRITE;
            WRITE:   next_state = is_last_byte(R_count) ? IDLE : READ;
            default: next_state = IDLE;
        endcase
    end

    // Sequencer state, parity, page/count and read-data latch; advance only on ticks
    always_ff @(posedge I_clock or negedge I_reset) begin
        if (!I_reset) begin
            R_state <= IDLE;
            R_odd   <= 1'b0;
            R_page  <= 8'd0;
            R_count <= '0;
            R_data  <= 8'd0;
        end else if (I_tick) begin
            R_odd   <= ~R_odd;
            R_state <= next_state;
            if (R_state == IDLE && trigger) begin
                R_page  <= I_cpu_data;
                R_count <= '0;
            end
            if (R_state == READ) begin
                R_data <= I_mem_data;
            end
            if (R_state == WRITE) begin
                R_count <= R_count + C_count_w'(1);
            end
        end
    end

    // Bus outputs decoded from state; the video write strobe is confined to tick clocks
    always_comb begin
        O_busy     = (R_state != IDLE);
        O_cpu_halt = (R_state != IDLE);
        O_mem_addr = 16'd0;
        O_mem_rden = 1'b0;
        O_ppu_addr = 3'd0;
        O_ppu_wren = 1'b0;
        O_ppu_data = 8'd0;
        if (R_state == READ) begin
            O_mem_addr = {R_page, R_count};
            O_mem_rden = 1'b1;
        end
        if (R_state == WRITE) begin
            O_ppu_addr = P_ppu_reg;
            O_ppu_data = R_data;
            O_ppu_wren = I_tick;
        end
    end

endmodule

// File: doc/oam_dma.md
# oam_dma

Sprite-attribute DMA engine that sits on the host side of the video block's host register port and acts as its initiator. A CPU write to the trigger address starts a transfer. The engine halts the CPU and reads 256 bytes from page `{page,8'h00}..{page,8'hFF}` of CPU memory. Each byte is written into the video block's sprite-data register through the same address/wren/data port the CPU uses.

## Interface
Parameters:
- `P_trigger_addr`, default `16'h4014`: CPU address whose write starts a transfer.
- `P_ppu_reg`, default `3'd4`: video host register index that receives each byte.

Ports:
- `I_clock`  in  1  master clock; the only clock.
- `I_reset`  in  1  asynchronous, active-low reset.
- `I_tick`  in  1  one-clock strobe, once per CPU cycle; all state advances only on clocks with `I_tick`=1.
- `I_cpu_addr`  in  16  CPU bus address.
- `I_cpu_wren`  in  1  CPU write strobe, sampled with `I_tick`.
- `I_cpu_data`  in  8  CPU write data; its value becomes the page number.
- `O_cpu_halt`  out  1  high while the engine owns the bus.
- `O_mem_addr`  out  16  DMA read address.
- `O_mem_rden`  out  1  DMA read enable.
- `I_mem_data`  in  8  read data, valid on the `I_tick` clock of a read cycle.
- `O_ppu_addr`  out  3  video host register index.
- `O_ppu_wren`  out  1  video host write strobe.
- `O_ppu_data`  out  8  video host write data.
- `O_busy`  out  1  state is not IDLE.

## Operation
- Parity: `R_odd` resets to 0 and toggles on every tick. The value before the toggle is that tick's parity. Even ticks are "get" cycles; odd ticks are "put" cycles.
- States: IDLE, HALT, ALIGN, READ, WRITE.
- IDLE: a tick with `I_cpu_wren`=1 and `I_cpu_addr`==`P_trigger_addr` does three things:
  - latches `R_page <= I_cpu_data`;
  - clears `R_count <= 8'd0`;
  - moves to HALT.
- HALT: lasts one tick. It goes to READ if the next tick is even, otherwise to ALIGN.
- ALIGN: lasts one tick, then goes to READ.
- READ (always an even tick):
  - `O_mem_addr = {R_page,R_count}` and `O_mem_rden`=1;
  - `R_data <= I_mem_data` is captured on the `I_tick` clock;
  - then goes to WRITE.
- WRITE (always an odd tick):
  - `O_ppu_addr=P_ppu_reg` and `O_ppu_data=R_data`;
  - `O_ppu_wren`=1 on the `I_tick` clock only;
  - `R_count` increments;
  - if `R_count` was 8'hFF, go to IDLE, otherwise go to READ.
- The count is 8 bits and wraps within the page; no carry reaches `R_page`, so page 8'hFF reads `16'hFF00..16'hFFFF`.
- Trigger writes while not IDLE are ignored; `R_page` is unchanged.
- Outside READ: `O_mem_rden`=0 and `O_mem_addr`=0.
- Outside WRITE: `O_ppu_wren`=0, `O_ppu_addr`=0 and `O_ppu_data`=0.

## Timing
- Reset values:
  - `O_cpu_halt`=0, `O_busy`=0;
  - `O_mem_addr`=0, `O_mem_rden`=0;
  - `O_ppu_addr`=0, `O_ppu_wren`=0, `O_ppu_data`=0;
  - state=IDLE, `R_odd`=0, `R_count`=0, `R_page`=0.
- `O_cpu_halt` and `O_busy` rise on the clock after the trigger tick. They fall on the clock after the final WRITE tick.
- Halt duration:
  - trigger on an even tick: 513 ticks (HALT + 256×(READ,WRITE));
  - trigger on an odd tick: 514 ticks (HALT, ALIGN, then the pairs).
- Read-to-write latency: the byte read on tick N is written on tick N+1.
- Clocks without `I_tick` hold all state and outputs, except `O_ppu_wren`, which is 0.
- Reset asserted mid-transfer: immediately returns to IDLE with halt low. No further writes occur, and the partial transfer is not resumed.

## Structure
- Shared package `dma_pkg` holds:
  - state enum `T_dma_state` (IDLE, HALT, ALIGN, READ, WRITE);
  - constants `C_dma_bytes`=256 and `C_oam_reg`=3'd4.
- The block is a single module with no sub-module. The state register, parity flag, page and count registers and the data latch live in one clocked process; output decode is combinational from state.

## Test plan
- Trigger `data=8'h02` on an even tick, memory returns `addr[7:0]`:
  - 256 `O_ppu_wren` pulses with `O_ppu_addr`=4 and data 0..255 in order;
  - `O_cpu_halt` high for exactly 513 ticks.
- Same trigger on an odd tick -> one ALIGN tick; halt high for exactly 514 ticks; first READ on an even tick.
- Page 8'hFF -> addresses `16'hFF00..16'hFFFF`, last address `16'hFFFF`; no access to `16'h0000`.
- Second write to `16'h4014` (data 8'h07) at byte 100 -> ignored; all 256 bytes still come from page 8'h02.
- Reset pulled low at byte 37 -> halt and busy drop immediately; no further `O_ppu_wren`. A new trigger afterwards completes a full 256-byte transfer.
- Writes to `16'h4013`/`16'h4015`, or to `16'h4014` with `I_tick`=0 -> no transfer starts; `O_busy` stays 0.
